tile_xy_route_fifo: RTL and testbench

Parametrised one-dimensional mesh hop buffer for the tile XY interconnect. Each instance sits on one axis (X or Y) of a tile. It accepts flits from the lower neighbour, the upper neighbour and local injection. Each flit is steered into one of three FIFOs by comparing its destination coordinate with this tile's coordinate:
- up-going FIFO
- down-going FIFO
- local eject FIFO

All ports use valid/ready handshakes; no transfer is ever dropped.

---
 rtl/tile_xy_route_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_tile_xy_route_fifo.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_xy_route_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tile_xy_route_fifo
// Purpose  : One-axis mesh hop buffer steering lo/hi/local flits into up, down
//            and eject FIFOs by destination coordinate.
// Revision : 1.0 - initial release
// =============================================================================

module tile_xy_route_fifo_buf #(
    parameter int W     = 68,
    parameter int DEPTH = 8,
    parameter int AFULL = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_out_ready,
    output logic                     o_out_valid,
    output logic [W-1:0]             o_out_data,
    output logic                     o_full,
    output logic                     o_afull,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_AFULL_CNT = (c_PTR_W + 1)'(AFULL);

    logic [W-1:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_cnt;
    logic                 w_push;
    logic                 w_pop;

    // A full buffer refuses pushes even while popping: no pass-through path.
    assign o_full      = (r_cnt == c_DEPTH_CNT);
    assign w_push      = i_push & ~o_full;
    assign o_out_valid = (r_cnt != '0);
    assign w_pop       = o_out_valid & i_out_ready;
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_afull     = (r_cnt >= c_AFULL_CNT);
    assign o_cnt       = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end
endmodule

module tile_xy_route_fifo #(
    parameter int DW     = 64,
    parameter int CW     = 2,
    parameter int DEPTH  = 8,
    parameter int TILE_X = 0,
    parameter int TILE_Y = 0,
    parameter int AXIS   = 0,
    parameter int AFULL  = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lo_in_valid,
    input  logic [DW+2*CW-1:0]       lo_in_flit,
    output logic                     lo_in_ready,
    input  logic                     hi_in_valid,
    input  logic [DW+2*CW-1:0]       hi_in_flit,
    output logic                     hi_in_ready,
    input  logic                     inj_valid,
    input  logic [DW+2*CW-1:0]       inj_flit,
    output logic                     inj_ready,
    output logic                     up_out_valid,
    output logic [DW+2*CW-1:0]       up_out_flit,
    input  logic                     up_out_ready,
    output logic                     dn_out_valid,
    output logic [DW+2*CW-1:0]       dn_out_flit,
    input  logic                     dn_out_ready,
    output logic                     ej_valid,
    output logic [DW+2*CW-1:0]       ej_flit,
    input  logic                     ej_ready,
    output logic                     up_afull,
    output logic                     dn_afull,
    output logic                     ej_afull,
    output logic [$clog2(DEPTH):0]   up_cnt,
    output logic [$clog2(DEPTH):0]   dn_cnt,
    output logic [$clog2(DEPTH):0]   ej_cnt
);
    localparam int            c_FW      = DW + 2 * CW;
    localparam logic [CW-1:0] c_TILE    = (AXIS == 0) ? CW'(TILE_X) : CW'(TILE_Y);
    localparam logic [1:0]    c_SRC_LO  = 2'd0;
    localparam logic [1:0]    c_SRC_HI  = 2'd1;
    localparam logic [1:0]    c_SRC_INJ = 2'd2;

    logic [CW-1:0] w_lo_key;
    logic [CW-1:0] w_hi_key;
    logic [CW-1:0] w_inj_key;

    generate
        if (AXIS == 0) begin : g_key_x
            assign w_lo_key  = lo_in_flit[DW +: CW];
            assign w_hi_key  = hi_in_flit[DW +: CW];
            assign w_inj_key = inj_flit[DW +: CW];
        end else begin : g_key_y
            assign w_lo_key  = lo_in_flit[DW+CW +: CW];
            assign w_hi_key  = hi_in_flit[DW+CW +: CW];
            assign w_inj_key = inj_flit[DW+CW +: CW];
        end
    endgenerate

    logic w_lo_ej_req, w_lo_up_req;
    logic w_hi_ej_req, w_hi_dn_req;
    logic w_inj_ej_req, w_inj_up_req, w_inj_dn_req;

    assign w_lo_ej_req  = lo_in_valid & (w_lo_key == c_TILE);
    assign w_lo_up_req  = lo_in_valid & (w_lo_key != c_TILE);
    assign w_hi_ej_req  = hi_in_valid & (w_hi_key == c_TILE);
    assign w_hi_dn_req  = hi_in_valid & (w_hi_key != c_TILE);
    assign w_inj_ej_req = inj_valid & (w_inj_key == c_TILE);
    assign w_inj_up_req = inj_valid & (w_inj_key > c_TILE);
    assign w_inj_dn_req = inj_valid & (w_inj_key < c_TILE);

    logic w_up_full, w_dn_full, w_ej_full;

    // Eject round-robin: first requester at or after the pointer, lo/hi/inj order.
    logic [1:0] r_ej_ptr;
    logic [2:0] w_ej_req;
    logic [1:0] w_ej_gnt;

    assign w_ej_req = {w_inj_ej_req, w_hi_ej_req, w_lo_ej_req};

    always_comb begin
        w_ej_gnt = c_SRC_LO;
        case (r_ej_ptr)
            2'd1: begin
                if (w_ej_req[1])      w_ej_gnt = c_SRC_HI;
                else if (w_ej_req[2]) w_ej_gnt = c_SRC_INJ;
                else                  w_ej_gnt = c_SRC_LO;
            end
            2'd2: begin
                if (w_ej_req[2])      w_ej_gnt = c_SRC_INJ;
                else if (w_ej_req[0]) w_ej_gnt = c_SRC_LO;
                else                  w_ej_gnt = c_SRC_HI;
            end
            default: begin
                if (w_ej_req[0])      w_ej_gnt = c_SRC_LO;
                else if (w_ej_req[1]) w_ej_gnt = c_SRC_HI;
                else                  w_ej_gnt = c_SRC_INJ;
            end
        endcase
    end

    logic w_up_push, w_dn_push, w_ej_push;
    logic [c_FW-1:0] w_up_data, w_dn_data, w_ej_data;

    assign w_up_push = ~rst & ~w_up_full & (w_lo_up_req | w_inj_up_req);
    assign w_dn_push = ~rst & ~w_dn_full & (w_hi_dn_req | w_inj_dn_req);
    assign w_ej_push = ~rst & ~w_ej_full & (|w_ej_req);
    assign w_up_data = w_lo_up_req ? lo_in_flit : inj_flit;
    assign w_dn_data = w_hi_dn_req ? hi_in_flit : inj_flit;

    always_comb begin
        w_ej_data = lo_in_flit;
        case (w_ej_gnt)
            c_SRC_HI:  w_ej_data = hi_in_flit;
            c_SRC_INJ: w_ej_data = inj_flit;
            default:   w_ej_data = lo_in_flit;
        endcase
    end

    assign lo_in_ready = ~rst & ((w_lo_ej_req & (w_ej_gnt == c_SRC_LO) & ~w_ej_full)
                               | (w_lo_up_req & ~w_up_full));
    assign hi_in_ready = ~rst & ((w_hi_ej_req & (w_ej_gnt == c_SRC_HI) & ~w_ej_full)
                               | (w_hi_dn_req & ~w_dn_full));
    assign inj_ready   = ~rst & ((w_inj_ej_req & (w_ej_gnt == c_SRC_INJ) & ~w_ej_full)
                               | (w_inj_up_req & ~w_lo_up_req & ~w_up_full)
                               | (w_inj_dn_req & ~w_hi_dn_req & ~w_dn_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ej_ptr <= 2'd0;
        end else if (w_ej_push) begin
            r_ej_ptr <= (w_ej_gnt == c_SRC_INJ) ? c_SRC_LO : w_ej_gnt + 2'd1;
        end
    end

    tile_xy_route_fifo_buf #(.W(c_FW), .DEPTH(DEPTH), .AFULL(AFULL)) u_up_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_up_push),
        .i_push_data (w_up_data),
        .i_out_ready (up_out_ready),
        .o_out_valid (up_out_valid),
        .o_out_data  (up_out_flit),
        .o_full      (w_up_full),
        .o_afull     (up_afull),
        .o_cnt       (up_cnt)
    );

    tile_xy_route_fifo_buf #(.W(c_FW), .DEPTH(DEPTH), .AFULL(AFULL)) u_dn_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_dn_push),
        .i_push_data (w_dn_data),
        .i_out_ready (dn_out_ready),
        .o_out_valid (dn_out_valid),
        .o_out_data  (dn_out_flit),
        .o_full      (w_dn_full),
        .o_afull     (dn_afull),
        .o_cnt       (dn_cnt)
    );

    tile_xy_route_fifo_buf #(.W(c_FW), .DEPTH(DEPTH), .AFULL(AFULL)) u_ej_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_ej_push),
        .i_push_data (w_ej_data),
        .i_out_ready (ej_ready),
        .o_out_valid (ej_valid),
        .o_out_data  (ej_flit),
        .o_full      (w_ej_full),
        .o_afull     (ej_afull),
        .o_cnt       (ej_cnt)
    );
endmodule

`default_nettype wire

// File: tb/tb_tile_xy_route_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tb_tile_xy_route_fifo
// Purpose  : Scoreboard bench for tile_xy_route_fifo (TILE_X=1, AXIS=0).
// Revision : 1.0 - initial release
// =============================================================================

module tb_tile_xy_route_fifo;
    localparam int DW = 16;
    localparam int CW = 2;
    localparam int FW = DW + 2 * CW;
    localparam int DEPTH = 8;
    localparam logic [1:0] TX = 2'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lo_in_valid = 1'b0, hi_in_valid = 1'b0, inj_valid = 1'b0;
    logic [FW-1:0] lo_in_flit = '0, hi_in_flit = '0, inj_flit = '0;
    logic lo_in_ready, hi_in_ready, inj_ready;
    logic up_out_valid, dn_out_valid, ej_valid;
    logic [FW-1:0] up_out_flit, dn_out_flit, ej_flit;
    logic up_out_ready = 1'b1, dn_out_ready = 1'b1, ej_ready = 1'b1;
    logic up_afull, dn_afull, ej_afull;
    logic [3:0] up_cnt, dn_cnt, ej_cnt;

    int total = 0;
    int bad = 0;

    logic [FW-1:0] up_q[$];
    logic [FW-1:0] dn_q[$];
    logic [FW-1:0] ej_q[$];

    tile_xy_route_fifo #(
        .DW(DW), .CW(CW), .DEPTH(DEPTH), .TILE_X(1), .TILE_Y(2), .AXIS(0), .AFULL(6)
    ) dut (
        .clk(clk), .rst(rst),
        .lo_in_valid(lo_in_valid), .lo_in_flit(lo_in_flit), .lo_in_ready(lo_in_ready),
        .hi_in_valid(hi_in_valid), .hi_in_flit(hi_in_flit), .hi_in_ready(hi_in_ready),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .up_out_valid(up_out_valid), .up_out_flit(up_out_flit), .up_out_ready(up_out_ready),
        .dn_out_valid(dn_out_valid), .dn_out_flit(dn_out_flit), .dn_out_ready(dn_out_ready),
        .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
        .up_afull(up_afull), .dn_afull(dn_afull), .ej_afull(ej_afull),
        .up_cnt(up_cnt), .dn_cnt(dn_cnt), .ej_cnt(ej_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] mk(input logic [1:0] dy, input logic [1:0] dx,
                                         input logic [15:0] p);
        return {dy, dx, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable between posedge+1 and the next posedge,
    // so handshakes seen at the negedge are those completing on the next edge.
    logic          up_stall = 1'b0, dn_stall = 1'b0, ej_stall = 1'b0;
    logic [FW-1:0] up_hold, dn_hold, ej_hold;
    always @(negedge clk) begin
        logic [FW-1:0] e;
        int n_up, n_dn, n_ej;
        if (rst) begin
            up_q.delete(); dn_q.delete(); ej_q.delete();
            up_stall = 1'b0; dn_stall = 1'b0; ej_stall = 1'b0;
        end else begin
            if (up_out_valid && up_out_ready) begin
                total++;
                if (up_q.size() == 0) begin
                    bad++; $display("FAIL up_unexpected got=%h required=none", up_out_flit);
                end else begin
                    e = up_q.pop_front();
                    if (up_out_flit !== e) begin
                        bad++; $display("FAIL up_order got=%h required=%h", up_out_flit, e);
                    end
                end
            end
            if (dn_out_valid && dn_out_ready) begin
                total++;
                if (dn_q.size() == 0) begin
                    bad++; $display("FAIL dn_unexpected got=%h required=none", dn_out_flit);
                end else begin
                    e = dn_q.pop_front();
                    if (dn_out_flit !== e) begin
                        bad++; $display("FAIL dn_order got=%h required=%h", dn_out_flit, e);
                    end
                end
            end
            if (ej_valid && ej_ready) begin
                total++;
                if (ej_q.size() == 0) begin
                    bad++; $display("FAIL ej_unexpected got=%h required=none", ej_flit);
                end else begin
                    e = ej_q.pop_front();
                    if (ej_flit !== e) begin
                        bad++; $display("FAIL ej_order got=%h required=%h", ej_flit, e);
                    end
                end
            end
            if (up_stall) begin
                total++;
                if (up_out_flit !== up_hold) begin
                    bad++; $display("FAIL up_stable got=%h required=%h", up_out_flit, up_hold);
                end
            end
            if (dn_stall) begin
                total++;
                if (dn_out_flit !== dn_hold) begin
                    bad++; $display("FAIL dn_stable got=%h required=%h", dn_out_flit, dn_hold);
                end
            end
            if (ej_stall) begin
                total++;
                if (ej_flit !== ej_hold) begin
                    bad++; $display("FAIL ej_stable got=%h required=%h", ej_flit, ej_hold);
                end
            end
            up_stall = up_out_valid && !up_out_ready; up_hold = up_out_flit;
            dn_stall = dn_out_valid && !dn_out_ready; dn_hold = dn_out_flit;
            ej_stall = ej_valid && !ej_ready;         ej_hold = ej_flit;

            total++;
            if (up_out_valid !== (up_cnt != 0) || dn_out_valid !== (dn_cnt != 0) ||
                ej_valid !== (ej_cnt != 0)) begin
                bad++;
                $display("FAIL valid_vs_cnt got=%b%b%b cnt=%0d/%0d/%0d required=valid iff cnt!=0",
                         up_out_valid, dn_out_valid, ej_valid, up_cnt, dn_cnt, ej_cnt);
            end

            n_up = 0; n_dn = 0; n_ej = 0;
            if (lo_in_valid && lo_in_ready) begin
                if (lo_in_flit[17:16] == TX) begin ej_q.push_back(lo_in_flit); n_ej++; end
                else begin up_q.push_back(lo_in_flit); n_up++; end
            end
            if (hi_in_valid && hi_in_ready) begin
                if (hi_in_flit[17:16] == TX) begin ej_q.push_back(hi_in_flit); n_ej++; end
                else begin dn_q.push_back(hi_in_flit); n_dn++; end
            end
            if (inj_valid && inj_ready) begin
                if (inj_flit[17:16] == TX) begin ej_q.push_back(inj_flit); n_ej++; end
                else if (inj_flit[17:16] > TX) begin up_q.push_back(inj_flit); n_up++; end
                else begin dn_q.push_back(inj_flit); n_dn++; end
            end
            if (n_up + n_dn + n_ej > 0) begin
                total++;
                if (n_up > 1 || n_dn > 1 || n_ej > 1 ||
                    (n_up > 0 && up_cnt == DEPTH) || (n_dn > 0 && dn_cnt == DEPTH) ||
                    (n_ej > 0 && ej_cnt == DEPTH)) begin
                    bad++;
                    $display("FAIL push_legal got=up%0d dn%0d ej%0d cnt=%0d/%0d/%0d required=<=1 each, none when full",
                             n_up, n_dn, n_ej, up_cnt, dn_cnt, ej_cnt);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        lo_in_valid = 1'b1; lo_in_flit = mk(0, 2, 16'h0001);
        hi_in_valid = 1'b1; hi_in_flit = mk(0, 1, 16'h0002);
        inj_valid   = 1'b1; inj_flit   = mk(0, 0, 16'h0003);
        tick(); tick();
        total++;
        if ({lo_in_ready, hi_in_ready, inj_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b required=000", {lo_in_ready, hi_in_ready, inj_ready});
        end
        lo_in_valid = 1'b0; hi_in_valid = 1'b0; inj_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (up_cnt !== 4'd0 || dn_cnt !== 4'd0 || ej_cnt !== 4'd0 ||
            {up_out_valid, dn_out_valid, ej_valid} !== 3'b000 ||
            {up_afull, dn_afull, ej_afull} !== 3'b000) begin
            bad++;
            $display("FAIL reset_state got=cnt %0d/%0d/%0d valid %b%b%b afull %b%b%b required=all zero",
                     up_cnt, dn_cnt, ej_cnt, up_out_valid, dn_out_valid, ej_valid,
                     up_afull, dn_afull, ej_afull);
        end
    endtask

    // Each row: source (0 lo, 1 hi, 2 inj), dst_x, expected output (0 up, 1 dn, 2 ej).
    task automatic test_routing();
        int src[9] = '{2, 2, 2, 1, 1, 1, 0, 0, 0};
        int dst[9] = '{3, 1, 0, 1, 3, 0, 0, 1, 2};
        int tgt[9] = '{0, 2, 1, 2, 1, 1, 0, 2, 0};
        up_out_ready = 1'b1; dn_out_ready = 1'b1; ej_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [FW-1:0] f;
            logic rdy, v;
            logic [FW-1:0] of;
            logic [3:0] c;
            f = mk(2'(i), 2'(dst[i]), 16'hA000 + 16'(i));
            case (src[i])
                0: begin lo_in_valid = 1'b1; lo_in_flit = f; end
                1: begin hi_in_valid = 1'b1; hi_in_flit = f; end
                default: begin inj_valid = 1'b1; inj_flit = f; end
            endcase
            #1;
            rdy = (src[i] == 0) ? lo_in_ready : (src[i] == 1) ? hi_in_ready : inj_ready;
            v = (tgt[i] == 0) ? up_out_valid : (tgt[i] == 1) ? dn_out_valid : ej_valid;
            total++;
            if (rdy !== 1'b1 || v !== 1'b0) begin
                bad++; $display("FAIL route_accept%0d got=ready%b outvalid%b required=ready1 outvalid0", i, rdy, v);
            end
            tick();
            lo_in_valid = 1'b0; hi_in_valid = 1'b0; inj_valid = 1'b0;
            #1;
            v  = (tgt[i] == 0) ? up_out_valid : (tgt[i] == 1) ? dn_out_valid : ej_valid;
            of = (tgt[i] == 0) ? up_out_flit  : (tgt[i] == 1) ? dn_out_flit  : ej_flit;
            c  = (tgt[i] == 0) ? up_cnt       : (tgt[i] == 1) ? dn_cnt       : ej_cnt;
            total++;
            if (v !== 1'b1 || of !== f || c !== 4'd1 ||
                up_cnt + dn_cnt + ej_cnt !== 4'd1) begin
                bad++;
                $display("FAIL route%0d got=valid%b flit%h cnt%0d/%0d/%0d required=valid1 flit%h in output %0d",
                         i, v, of, up_cnt, dn_cnt, ej_cnt, f, tgt[i]);
            end
            tick();
        end
    endtask

    task automatic test_up_priority();
        up_out_ready = 1'b0;
        inj_valid = 1'b1; inj_flit = mk(0, 2, 16'h2000);
        lo_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lo_in_flit = mk(0, 2, 16'h1000 + 16'(k));
            #1;
            total++;
            if (lo_in_ready !== 1'b1 || inj_ready !== 1'b0) begin
                bad++; $display("FAIL up_prio%0d got=lo%b inj%b required=lo1 inj0", k, lo_in_ready, inj_ready);
            end
            tick();
            total++;
            if (up_cnt !== 4'(k + 1) || up_afull !== (k + 1 >= 6)) begin
                bad++;
                $display("FAIL up_fill%0d got=cnt%0d afull%b required=cnt%0d afull%b",
                         k, up_cnt, up_afull, k + 1, (k + 1 >= 6));
            end
        end
        #1;
        total++;
        if (lo_in_ready !== 1'b0 || inj_ready !== 1'b0 || up_cnt !== 4'd8 || up_afull !== 1'b1) begin
            bad++;
            $display("FAIL up_full got=lo%b inj%b cnt%0d afull%b required=lo0 inj0 cnt8 afull1",
                     lo_in_ready, inj_ready, up_cnt, up_afull);
        end
        lo_in_valid = 1'b0;
        #1;
        total++;
        if (inj_ready !== 1'b0) begin
            bad++; $display("FAIL up_full_inj got=%b required=0", inj_ready);
        end
        inj_valid = 1'b0;
        up_out_ready = 1'b1;
        for (int i = 0; i < 40 && up_cnt != 0; i++) tick();
        total++;
        if (up_cnt !== 4'd0) begin
            bad++; $display("FAIL up_drain got=%0d required=0", up_cnt);
        end
    endtask

    task automatic test_ej_rr();
        logic [15:0] seq[3] = '{16'h3000, 16'h4000, 16'h5000};
        logic [2:0] exp_rdy;
        rst = 1'b1; tick(); rst = 1'b0;
        ej_ready = 1'b1;
        lo_in_valid = 1'b1; hi_in_valid = 1'b1; inj_valid = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            lo_in_flit = mk(0, 1, seq[0]);
            hi_in_flit = mk(1, 1, seq[1]);
            inj_flit   = mk(2, 1, seq[2]);
            #1;
            exp_rdy = 3'b001 << (cyc % 3);
            total++;
            if ({inj_ready, hi_in_ready, lo_in_ready} !== exp_rdy) begin
                bad++;
                $display("FAIL ej_rr%0d got=%b required=%b (inj,hi,lo)", cyc,
                         {inj_ready, hi_in_ready, lo_in_ready}, exp_rdy);
            end
            tick();
            seq[cyc % 3] = seq[cyc % 3] + 16'd1;
            total++;
            if (ej_cnt !== 4'd1) begin
                bad++; $display("FAIL ej_rr_cnt%0d got=%0d required=1", cyc, ej_cnt);
            end
        end
        lo_in_valid = 1'b0; hi_in_valid = 1'b0; inj_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_ej_full();
        logic [15:0] p = 16'h6000;
        ej_ready = 1'b0;
        lo_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lo_in_flit = mk(3, 1, p);
            #1;
            total++;
            if (lo_in_ready !== 1'b1) begin
                bad++; $display("FAIL ej_fill%0d got=%b required=1", k, lo_in_ready);
            end
            tick();
            p++;
        end
        lo_in_flit = mk(3, 1, p);
        #1;
        total++;
        if (ej_cnt !== 4'd8 || ej_afull !== 1'b1 || lo_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ej_full got=cnt%0d afull%b ready%b required=cnt8 afull1 ready0",
                     ej_cnt, ej_afull, lo_in_ready);
        end
        ej_ready = 1'b1;
        #1;
        total++;
        if (lo_in_ready !== 1'b0) begin
            bad++; $display("FAIL ej_full_pop_ready got=%b required=0", lo_in_ready);
        end
        tick();
        total++;
        if (ej_cnt !== 4'd7) begin
            bad++; $display("FAIL ej_pop_only got=%0d required=7", ej_cnt);
        end
        for (int k = 0; k < 20; k++) begin
            lo_in_flit = mk(3, 1, p);
            #1;
            total++;
            if (lo_in_ready !== 1'b1) begin
                bad++; $display("FAIL ej_stream%0d got=%b required=1", k, lo_in_ready);
            end
            tick();
            p++;
            total++;
            if (ej_cnt !== 4'd7) begin
                bad++; $display("FAIL ej_stream_cnt%0d got=%0d required=7", k, ej_cnt);
            end
        end
        lo_in_valid = 1'b0;
        for (int i = 0; i < 40 && ej_cnt != 0; i++) tick();
        total++;
        if (ej_cnt !== 4'd0) begin
            bad++; $display("FAIL ej_drain got=%0d required=0", ej_cnt);
        end
    endtask

    task automatic test_reset_mid();
        up_out_ready = 1'b0; dn_out_ready = 1'b1; ej_ready = 1'b1;
        // A lone lo eject push leaves the round-robin pointer at hi.
        lo_in_valid = 1'b1; lo_in_flit = mk(0, 1, 16'h7000);
        tick();
        for (int k = 0; k < 5; k++) begin
            lo_in_flit = mk(0, 2, 16'h7100 + 16'(k));
            tick();
        end
        total++;
        if (up_cnt !== 4'd5) begin
            bad++; $display("FAIL mid_fill got=%0d required=5", up_cnt);
        end
        lo_in_flit = mk(0, 1, 16'h7200);
        hi_in_valid = 1'b1; hi_in_flit = mk(0, 3, 16'h7300);
        inj_valid = 1'b1; inj_flit = mk(0, 1, 16'h7400);
        rst = 1'b1;
        #1;
        total++;
        if ({lo_in_ready, hi_in_ready, inj_ready} !== 3'b000) begin
            bad++; $display("FAIL mid_rst_ready got=%b required=000", {lo_in_ready, hi_in_ready, inj_ready});
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (up_cnt !== 4'd0 || {up_out_valid, dn_out_valid, ej_valid} !== 3'b000) begin
            bad++;
            $display("FAIL mid_rst_state got=cnt%0d valid%b%b%b required=cnt0 valid000",
                     up_cnt, up_out_valid, dn_out_valid, ej_valid);
        end
        total++;
        if ({lo_in_ready, hi_in_ready, inj_ready} !== 3'b110) begin
            bad++;
            $display("FAIL mid_rst_ptr got=%b required=110 (lo,hi,inj)", {lo_in_ready, hi_in_ready, inj_ready});
        end
        lo_in_valid = 1'b0; hi_in_valid = 1'b0; inj_valid = 1'b0;
        up_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({up_out_valid, dn_out_valid, ej_valid} !== 3'b000) begin
                bad++;
                $display("FAIL mid_rst_leak%0d got=%b%b%b required=000", k, up_out_valid, dn_out_valid, ej_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_up_priority();
        test_ej_rr();
        test_ej_full();
        test_reset_mid();
        tick();
        total++;
        if (up_q.size() != 0 || dn_q.size() != 0 || ej_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d/%0d/%0d required=0/0/0", up_q.size(), dn_q.size(), ej_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
